// File: rtl/idu_decode_stage.sv
// Decode stage: buffers fetch bundles in a small FIFO, decodes RV32I fields at enqueue, flushes on mispredict.
// Optional macro IDU_ILLEGAL_CHECK_EN enables illegal-instruction detection.
module idu_decode_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            id_in_valid,
  output logic            id_in_ready,
  input  logic [63:0]     id_in_bits,
  input  logic            id_out_ready,
  output logic            id_out_valid,
  output logic [XLEN-1:0] id_out_pc,
  output logic [31:0]     id_out_inst,
  output logic [4:0]      id_out_rs1,
  output logic [4:0]      id_out_rs2,
  output logic [4:0]      id_out_rd,
  output logic [XLEN-1:0] id_out_imm,
  output logic [3:0]      id_out_class,
  output logic            id_out_wen,
  output logic            id_out_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_OPIMM  = 4'd7;
  localparam logic [3:0] CLS_OP     = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_MISC   = 4'd10;
  localparam logic [3:0] CLS_UNK    = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
    logic            wen;
    logic            illegal;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic [31:0]        in_inst;
  logic [3:0]         dec_cls;
  logic [31:0]        imm32;
  logic               dec_wen;
  logic               dec_illegal;
  entry_t             dec;
  entry_t             head;
  logic               enq;
  logic               deq;

  assign in_inst = id_in_bits[31:0];

  // Field decode of the incoming instruction, done once at enqueue
  always_comb begin
    dec_cls     = CLS_UNK;
    imm32       = '0;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111: begin dec_cls = CLS_LUI;    imm32 = {in_inst[31:12], 12'b0}; end
      7'b0010111: begin dec_cls = CLS_AUIPC;  imm32 = {in_inst[31:12], 12'b0}; end
      7'b1101111: begin
        dec_cls = CLS_JAL;
        imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin dec_cls = CLS_JALR;   imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b1100011: begin
        dec_cls = CLS_BRANCH;
        imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0000011: begin dec_cls = CLS_LOAD;   imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0100011: begin dec_cls = CLS_STORE;  imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}; end
      7'b0010011: begin dec_cls = CLS_OPIMM;  imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0110011: dec_cls = CLS_OP;
      7'b1110011: begin dec_cls = CLS_SYSTEM; imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0001111: dec_cls = CLS_MISC;
      default: ;
    endcase
`ifdef IDU_ILLEGAL_CHECK_EN
    dec_illegal = (in_inst[1:0] != 2'b11) || (dec_cls == CLS_UNK) ||
                  ((dec_cls == CLS_OP) && !(in_inst[31:25] inside {7'h00, 7'h20, 7'h01}));
    if (dec_illegal) begin
      dec_cls = CLS_UNK;
      imm32   = '0;
    end
`endif
    dec_wen = (in_inst[11:7] != 5'd0) &&
              ((dec_cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_OP}) ||
               ((dec_cls == CLS_SYSTEM) && (in_inst[14:12] != 3'd0)));
  end

  always_comb begin
    dec.pc      = XLEN'(id_in_bits[63:32]);
    dec.inst    = in_inst;
    dec.imm     = XLEN'($signed(imm32));
    dec.cls     = dec_cls;
    dec.wen     = dec_wen;
    dec.illegal = dec_illegal;
  end

  // Handshake is driven only by registered occupancy and flush
  assign id_in_ready  = ~reset & ~flush & (count < CNT_W'(DEPTH));
  assign id_out_valid = (count != '0) & ~flush;
  assign enq          = id_in_valid & id_in_ready;
  assign deq          = id_out_valid & id_out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
      end
      if (deq) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      case ({enq, deq})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign id_out_pc      = head.pc;
  assign id_out_inst    = head.inst;
  assign id_out_rs1     = head.inst[19:15];
  assign id_out_rs2     = head.inst[24:20];
  assign id_out_rd      = head.inst[11:7];
  assign id_out_imm     = head.imm;
  assign id_out_class   = head.cls;
  assign id_out_wen     = head.wen;
  assign id_out_illegal = head.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Bench for idu_decode_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_idu_decode_stage;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        id_in_valid;
  logic        id_in_ready;
  logic [63:0] id_in_bits;
  logic        id_out_ready;
  logic        id_out_valid;
  logic [31:0] id_out_pc;
  logic [31:0] id_out_inst;
  logic [4:0]  id_out_rs1;
  logic [4:0]  id_out_rs2;
  logic [4:0]  id_out_rd;
  logic [31:0] id_out_imm;
  logic [3:0]  id_out_class;
  logic        id_out_wen;
  logic        id_out_illegal;

  idu_decode_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .id_in_valid(id_in_valid), .id_in_ready(id_in_ready), .id_in_bits(id_in_bits),
    .id_out_ready(id_out_ready), .id_out_valid(id_out_valid),
    .id_out_pc(id_out_pc), .id_out_inst(id_out_inst),
    .id_out_rs1(id_out_rs1), .id_out_rs2(id_out_rs2), .id_out_rd(id_out_rd),
    .id_out_imm(id_out_imm), .id_out_class(id_out_class),
    .id_out_wen(id_out_wen), .id_out_illegal(id_out_illegal)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: table lookup of opcode to class, class to format letter
  localparam logic [6:0] OPC_TAB [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                          7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
  function automatic void ref_decode(input logic [31:0] ins, output int cls,
                                     output logic [31:0] imm, output logic wen, output logic ill);
    string fmt = "UUJIBISIRIN";
    byte   f;
    int    v;
    cls = 15;
    for (int k = 0; k < 11; k++) if (ins[6:0] == OPC_TAB[k]) cls = k;
    f = (cls == 15) ? "N" : fmt[cls];
    v = 0;
    case (f)
      "I": v = $signed(ins[31:20]);
      "S": v = $signed({ins[31:25], ins[11:7]});
      "B": begin v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}); v = v * 2; end
      "J": begin v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}); v = v * 2; end
      "U": v = int'({ins[31:12], 12'h000});
      default: v = 0;
    endcase
    imm = 32'(v);
    ill = 1'b0;
`ifdef IDU_ILLEGAL_CHECK_EN
    ill = (ins[1:0] != 2'b11) || (cls == 15) ||
          (cls == 8 && ins[31:25] != 7'h00 && ins[31:25] != 7'h20 && ins[31:25] != 7'h01);
    if (ill) begin cls = 15; imm = 32'h0; end
`endif
    wen = (ins[11:7] != 5'd0) &&
          (cls <= 3 || cls == 5 || cls == 7 || cls == 8 || (cls == 9 && ins[14:12] != 3'd0));
  endfunction

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } txn_t;
  txn_t        q[$];
  logic [31:0] dut_log[$];

  // Model state advances on the clock edge from the stable driven inputs
  always @(posedge clock) begin
    bit do_enq, do_deq;
    if (reset || flush) begin
      q.delete();
    end else begin
      do_enq = id_in_valid && (q.size() < DEPTH);
      do_deq = (q.size() != 0) && id_out_ready;
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(txn_t'(id_in_bits));
    end
  end

  // Compare process: handshake every cycle, head fields whenever valid is expected
  always @(negedge clock) begin
    logic        exp_valid, exp_ready, e_wen, e_ill;
    logic [31:0] e_imm;
    int          e_cls;
    exp_valid = (q.size() != 0) && !flush;
    exp_ready = !reset && !flush && (q.size() < DEPTH);
    chk("m_valid", 32'(id_out_valid), 32'(exp_valid));
    chk("m_ready", 32'(id_in_ready), 32'(exp_ready));
    if (exp_valid) begin
      ref_decode(q[0].inst, e_cls, e_imm, e_wen, e_ill);
      chk("m_pc", id_out_pc, q[0].pc);
      chk("m_inst", id_out_inst, q[0].inst);
      chk("m_rs1", 32'(id_out_rs1), 32'(q[0].inst[19:15]));
      chk("m_rs2", 32'(id_out_rs2), 32'(q[0].inst[24:20]));
      chk("m_rd", 32'(id_out_rd), 32'(q[0].inst[11:7]));
      chk("m_imm", id_out_imm, e_imm);
      chk("m_class", 32'(id_out_class), 32'(e_cls));
      chk("m_wen", 32'(id_out_wen), 32'(e_wen));
      chk("m_illegal", 32'(id_out_illegal), 32'(e_ill));
    end
    if (id_out_valid && id_out_ready) dut_log.push_back(id_out_pc);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    id_in_valid = 1'b1;
    id_in_bits  = {pc, inst};
    step();
    id_in_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          p_cls;
    logic [31:0] p_imm;
    logic        p_wen, p_ill;
    int          idx, budget;
    bit          acc;

    reset = 1'b1; flush = 1'b0; id_in_valid = 1'b0; id_in_bits = '0; id_out_ready = 1'b0;

    // Pin the reference model itself
    ref_decode(32'hFE000EE3, p_cls, p_imm, p_wen, p_ill);
    chk("model_beq_imm", p_imm, 32'hFFFFFFFC);
    chk("model_beq_class", 32'(p_cls), 32'd4);
    ref_decode(32'h800000EF, p_cls, p_imm, p_wen, p_ill);
    chk("model_jal_imm", p_imm, 32'hFFF00000);
    chk("model_jal_wen", 32'(p_wen), 32'd1);

    repeat (3) step();
    @(negedge clock);
    chk("rst_valid", 32'(id_out_valid), 32'd0);
    chk("rst_ready", 32'(id_in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 32'(id_in_ready), 32'd1);
    chk("post_rst_valid", 32'(id_out_valid), 32'd0);
    chk("post_rst_pc", id_out_pc, 32'h0);
    chk("post_rst_class", 32'(id_out_class), 32'd0);

    // Single instruction
    id_out_ready = 1'b1;
    send(32'h30000000, 32'h00500093);
    chk("addi_valid", 32'(id_out_valid), 32'd1);
    chk("addi_class", 32'(id_out_class), 32'd7);
    chk("addi_rd", 32'(id_out_rd), 32'd1);
    chk("addi_rs1", 32'(id_out_rs1), 32'd0);
    chk("addi_imm", id_out_imm, 32'd5);
    chk("addi_wen", 32'(id_out_wen), 32'd1);
    step();
    @(negedge clock);
    chk("addi_drained", 32'(id_out_valid), 32'd0);

    // Backpressure: third push must wait until space frees
    dut_log.delete();
    id_out_ready = 1'b0;
    id_in_valid = 1'b1;
    id_in_bits = {32'h30000000, 32'h00100093}; step();
    id_in_bits = {32'h30000004, 32'h00200113}; step();
    id_in_bits = {32'h30000008, 32'h00300193};
    @(negedge clock);
    chk("bp_full_ready", 32'(id_in_ready), 32'd0);
    step();
    id_out_ready = 1'b1;
    step(); step();
    id_in_valid = 1'b0;
    step(); step();
    chk("bp_count", 32'(dut_log.size()), 32'd3);
    if (dut_log.size() == 3) begin
      chk("bp_order0", dut_log[0], 32'h30000000);
      chk("bp_order1", dut_log[1], 32'h30000004);
      chk("bp_order2", dut_log[2], 32'h30000008);
    end

    // Immediates
    send(32'h30000020, 32'hFE000EE3);
    chk("beq_imm", id_out_imm, 32'hFFFFFFFC);
    chk("beq_class", 32'(id_out_class), 32'd4);
    chk("beq_wen", 32'(id_out_wen), 32'd0);
    step();
    send(32'h30000024, 32'h800000EF);
    chk("jal_imm", id_out_imm, 32'hFFF00000);
    chk("jal_class", 32'(id_out_class), 32'd2);
    step();
    send(32'h30000028, 32'hFE112E23);
    chk("sw_imm", id_out_imm, 32'hFFFFFFFC);
    chk("sw_class", 32'(id_out_class), 32'd6);
    step();

    // Flush with two entries buffered and both handshakes offered
    dut_log.delete();
    id_out_ready = 1'b0;
    id_in_valid = 1'b1;
    id_in_bits = {32'h30000010, 32'h00100093}; step();
    id_in_bits = {32'h30000014, 32'h00200113}; step();
    flush = 1'b1; id_out_ready = 1'b1;
    id_in_bits = {32'h300000F0, 32'h00400213};
    @(negedge clock);
    chk("flush_valid", 32'(id_out_valid), 32'd0);
    chk("flush_ready", 32'(id_in_ready), 32'd0);
    step();
    flush = 1'b0; id_out_ready = 1'b0;
    id_in_bits = {32'h30000100, 32'h00500093};
    @(negedge clock);
    chk("postflush_valid", 32'(id_out_valid), 32'd0);
    chk("postflush_ready", 32'(id_in_ready), 32'd1);
    step();
    id_in_valid = 1'b0;
    @(negedge clock);
    chk("postflush_pc", id_out_pc, 32'h30000100);
    id_out_ready = 1'b1;
    step(); step();
    chk("postflush_log_n", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() == 1) chk("postflush_first", dut_log[0], 32'h30000100);

    // Pointer wrap with toggling downstream ready
    dut_log.delete();
    idx = 0; budget = 0;
    while (idx < 10 && budget < 100) begin
      id_in_valid  = 1'b1;
      id_in_bits   = {32'h30000200 + 32'(idx * 4), 32'h00000013 | (32'(idx + 1) << 7) | (32'(idx) << 20)};
      id_out_ready = budget[0] ? 1'b0 : 1'b1;
      @(negedge clock);
      acc = id_in_ready;
      step();
      if (acc) idx++;
      budget++;
    end
    if (budget >= 100) chk("wrap_budget", 32'(budget), 32'd0);
    id_in_valid = 1'b0; id_out_ready = 1'b1;
    repeat (4) step();
    chk("wrap_count", 32'(dut_log.size()), 32'd10);
    if (dut_log.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("wrap_order%0d", i), dut_log[i], 32'h30000200 + 32'(i * 4));

    // rd = x0 and unrecognised encodings
    send(32'h30000300, 32'h00001037);
    chk("lui_x0_wen", 32'(id_out_wen), 32'd0);
    chk("lui_x0_class", 32'(id_out_class), 32'd0);
    chk("lui_x0_imm", id_out_imm, 32'h00001000);
    step();
    send(32'h30000304, 32'h00000000);
    chk("zero_class", 32'(id_out_class), 32'd15);
    chk("zero_wen", 32'(id_out_wen), 32'd0);
`ifdef IDU_ILLEGAL_CHECK_EN
    chk("zero_illegal", 32'(id_out_illegal), 32'd1);
`else
    chk("zero_illegal", 32'(id_out_illegal), 32'd0);
`endif
    step();
    send(32'h30000308, 32'hFE000033);
`ifdef IDU_ILLEGAL_CHECK_EN
    chk("f7_class", 32'(id_out_class), 32'd15);
    chk("f7_illegal", 32'(id_out_illegal), 32'd1);
`else
    chk("f7_class", 32'(id_out_class), 32'd8);
    chk("f7_illegal", 32'(id_out_illegal), 32'd0);
`endif
    step();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
